// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential word-aligned fetch with an in-order prefetch queue feeding IF/ID.
// Latency: a response is written into the queue and appears on ifid the next cycle (2 cycles request-to-decode minimum).
// Backpressure: requests stall while DEPTH entries are allocated or stale responses are still owed; ifid_ready holds the head.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ifid_valid,
  input  logic        ifid_ready,
  output logic [31:0] ifid_instr,
  output logic [63:0] ifid_pc,
  output logic [63:0] ifid_pc_next
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // Queue storage: one pc/instr/filled triple per entry.
  logic [DEPTH-1:0][63:0] r_pc;
  logic [DEPTH-1:0][31:0] r_instr;
  logic [DEPTH-1:0]       r_filled;

  logic [63:0]   r_fetch_pc;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW-1:0] r_fill;
  logic [CW-1:0] r_alloc_cnt;   // entries allocated (filled or waiting for data)
  logic [CW-1:0] r_pend_cnt;    // allocated entries still waiting for data
  logic [CW-1:0] r_drop_cnt;    // responses owed to requests killed by a redirect

  logic          w_accept;
  logic          w_pop;
  logic          w_fill;
  logic          w_drop;
  logic [63:0]   w_redirect_tgt;
  logic [CW-1:0] w_owed;
  logic [CW-1:0] w_drop_redir;
  logic [CW-1:0] w_alloc_next;
  logic [CW-1:0] w_pend_next;

  // Handshake qualification; redirect suppresses both request and pop in its own cycle.
  always_comb begin
    imem_req_valid = !reset && !redirect_valid && (r_alloc_cnt < FULL_CNT) && (r_drop_cnt == '0);
    imem_req_addr  = r_fetch_pc;
    ifid_valid     = r_filled[r_head] && !redirect_valid;
    ifid_instr     = r_instr[r_head];
    ifid_pc        = r_pc[r_head];
    ifid_pc_next   = r_pc[r_head] + 64'd4;

    w_accept = imem_req_valid && imem_req_ready;
    w_pop    = ifid_valid && ifid_ready;
    // A response with nothing pending and nothing owed is unsolicited and falls through.
    w_drop   = imem_resp_valid && !redirect_valid && (r_drop_cnt != '0);
    w_fill   = imem_resp_valid && !redirect_valid && (r_drop_cnt == '0) && (r_pend_cnt != '0);

    w_redirect_tgt = redirect_pc & ~64'h3;
    // drop_cnt is only nonzero while the queue is empty, so the sum stays within DEPTH.
    w_owed         = r_drop_cnt + r_pend_cnt;
    w_drop_redir   = (imem_resp_valid && (w_owed != '0)) ? (w_owed - CNT_ONE) : w_owed;

    w_alloc_next = r_alloc_cnt + CW'(w_accept) - CW'(w_pop);
    w_pend_next  = r_pend_cnt + CW'(w_accept) - CW'(w_fill);
  end

  // Fetch PC, queue pointers and occupancy counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_head      <= '0;
      r_tail      <= '0;
      r_fill      <= '0;
      r_alloc_cnt <= '0;
      r_pend_cnt  <= '0;
      r_drop_cnt  <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc  <= w_redirect_tgt;
      r_head      <= '0;
      r_tail      <= '0;
      r_fill      <= '0;
      r_alloc_cnt <= '0;
      r_pend_cnt  <= '0;
      r_drop_cnt  <= w_drop_redir;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 64'd4;
        r_tail     <= r_tail + PTR_ONE;
      end
      if (w_fill) begin
        r_fill <= r_fill + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CNT_ONE;
      end
      r_alloc_cnt <= w_alloc_next;
      r_pend_cnt  <= w_pend_next;
    end
  end

  // Entry contents: allocate at tail, fill at the fill pointer, retire at head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= '0;
      r_instr  <= '0;
      r_filled <= '0;
    end else if (redirect_valid) begin
      r_filled <= '0;
    end else begin
      if (w_accept) begin
        r_pc[r_tail]     <= r_fetch_pc;
        r_filled[r_tail] <= 1'b0;
      end
      if (w_fill) begin
        r_instr[r_fill]  <= imem_resp_data;
        r_filled[r_fill] <= 1'b1;
      end
      if (w_pop) begin
        r_filled[r_head] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: randomized and directed stimulus against a queue-based reference model.
// Latency: one model step per clock; outputs sampled mid-cycle, model advanced at the rising edge.
// Backpressure: bench memory answers in order after a per-request latency; ifid_ready and req_ready toggled.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ifid_valid;
  logic        ifid_ready = 1'b0;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic [63:0] ifid_pc_next;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_ready     (ifid_ready),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_next   (ifid_pc_next)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] instr; bit filled; } ent_t;
  typedef struct { logic [63:0] addr; int due; } mreq_t;

  ent_t        m_q[$];     // expected queue contents, oldest first
  mreq_t       mem_q[$];   // requests the bench memory still has to answer
  logic [63:0] m_fpc;
  int          m_drop;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errs = 0;

  // Last sampled observations, for directed checks.
  bit          o_acc;
  bit          o_ivld;
  logic [63:0] o_addr;
  logic [63:0] o_ipc;
  logic [63:0] o_ipcn;
  int          o_cyc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drop = 0;
    m_fpc  = RST_PC;
  endtask

  // One clock cycle: drive, check against the model, then advance the model at the edge.
  task automatic step(input bit ir, input bit rr, input bit rv, input logic [63:0] rp,
                      input int lat, input bit ra);
    bit          resp_v;
    bit          exp_rv;
    bit          exp_iv;
    bit          done;
    logic [31:0] rdat;
    int          owed;
    ent_t        e;
    resp_v = 1'b0;
    if (ra && (mem_q.size() > 0)) resp_v = (mem_q[0].due <= cyc);
    rdat = resp_v ? mem_word(mem_q[0].addr) : 32'($urandom);
    ifid_ready      = ir;
    imem_req_ready  = rr;
    redirect_valid  = rv;
    redirect_pc     = rp;
    imem_resp_valid = resp_v;
    imem_resp_data  = rdat;
    #3;
    exp_rv = !rv && (m_q.size() < DEPTH) && (m_drop == 0);
    exp_iv = 1'b0;
    if (!rv && (m_q.size() > 0)) exp_iv = m_q[0].filled;
    check_eq("req_vld", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) check_eq("req_addr", imem_req_addr, m_fpc);
    check_eq("ifid_vld", 64'(ifid_valid), 64'(exp_iv));
    if (exp_iv) begin
      check_eq("ifid_pc", ifid_pc, m_q[0].pc);
      check_eq("ifid_instr", 64'(ifid_instr), 64'(m_q[0].instr));
      check_eq("ifid_pc_next", ifid_pc_next, m_q[0].pc + 64'd4);
    end
    o_acc  = imem_req_valid && rr;
    o_ivld = ifid_valid;
    o_addr = imem_req_addr;
    o_ipc  = ifid_pc;
    o_ipcn = ifid_pc_next;
    o_cyc  = cyc;
    @(posedge clk);
    if (rv) begin
      owed = m_drop;
      foreach (m_q[i]) if (!m_q[i].filled) owed++;
      if (resp_v && owed > 0) owed--;
      m_drop = owed;
      m_q.delete();
      m_fpc = {rp[63:2], 2'b00};
    end else begin
      if (resp_v) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          done = 1'b0;
          for (int i = 0; i < m_q.size(); i++) begin
            if (!done && !m_q[i].filled) begin
              e = m_q[i];
              e.filled = 1'b1;
              e.instr  = rdat;
              m_q[i]   = e;
              done     = 1'b1;
            end
          end
        end
      end
      if (exp_iv && ir) void'(m_q.pop_front());
      if (exp_rv && rr) begin
        m_q.push_back('{pc: m_fpc, instr: 32'h0, filled: 1'b0});
        mem_q.push_back('{addr: m_fpc, due: cyc + lat});
        m_fpc = m_fpc + 64'd4;
      end
    end
    if (resp_v) void'(mem_q.pop_front());
    cyc++;
    #1;
  endtask

  // Pulse reset between edges, check the reset-state outputs, release after one edge.
  task automatic do_reset(input bit keep_mem);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_req_vld", 64'(imem_req_valid), 64'd0);
    check_eq("rst_ifid_vld", 64'(ifid_valid), 64'd0);
    check_eq("rst_instr", 64'(ifid_instr), 64'd0);
    check_eq("rst_pc", ifid_pc, 64'd0);
    check_eq("rst_pc_next", ifid_pc_next, 64'd4);
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    model_reset();
    if (!keep_mem) mem_q.delete();
  endtask

  initial begin
    int          rel;
    int          first;
    int          cnt;
    bit          got;
    logic [63:0] pcs[$];

    model_reset();
    #1;

    // Streaming with a 1-cycle memory.
    do_reset(1'b0);
    rel = cyc; first = -1; cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 0, '0, 1, 1);
      if (o_ivld) begin
        if (first < 0) begin
          first = o_cyc - rel;
          check_eq("stream_pc0", o_ipc, RST_PC);
        end
        cnt++;
      end
    end
    check_eq("stream_first_lat", 64'(first), 64'd2);
    check_eq("stream_count", 64'(cnt), 64'd10);

    // Backpressure until full, then drain.
    do_reset(1'b0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, '0, 1, 1);
      if (o_acc) cnt++;
    end
    check_eq("full_req_count", 64'(cnt), 64'(DEPTH));
    pcs.delete();
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, '0, 1, 1);
      if (o_ivld) pcs.push_back(o_ipc);
    end
    check_eq("drain_count", 64'(pcs.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < pcs.size()) check_eq("drain_pc", pcs[k], RST_PC + 64'(4 * k));

    // Redirect with three requests in flight on a 3-cycle memory.
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) step(1, 1, 0, '0, 3, 1);
    step(1, 1, 1, 64'h2002, 3, 0);
    got = 1'b0; first = -1;
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 0, '0, 1, 1);
      if (o_acc && !got) begin
        got = 1'b1;
        check_eq("redir_restart_cyc", 64'(k), 64'd3);
        check_eq("redir_addr", o_addr, 64'h2000);
      end
      if (o_ivld && first < 0) begin
        first = 0;
        check_eq("redir_first_pc", o_ipc, 64'h2000);
      end
    end
    check_eq("redir_restarted", 64'(got), 64'd1);

    // Redirect coincident with a response and a ready decode stage.
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, '0, 2, 1);
    step(1, 1, 1, 64'h3000, 1, 1);
    step(1, 1, 0, '0, 1, 1);
    check_eq("coinc_empty", 64'(o_ivld), 64'd0);
    check_eq("coinc_owed", 64'(o_acc), 64'd0);
    step(1, 1, 0, '0, 1, 1);
    check_eq("coinc_resume", 64'(o_acc), 64'd1);
    check_eq("coinc_addr", o_addr, 64'h3000);

    // Fetch address wrap-around at the top of the address space.
    step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1);
    pcs.delete();
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 0, '0, 1, 1);
      if (o_acc) pcs.push_back(o_addr);
      if (o_ivld && o_ipc == 64'hFFFF_FFFF_FFFF_FFFC) begin
        got = 1'b1;
        check_eq("wrap_pc_next", o_ipcn, 64'h0);
      end
    end
    check_eq("wrap_seen_fffc", 64'(got), 64'd1);
    check_eq("wrap_req_count", 64'(pcs.size() >= 3), 64'd1);
    if (pcs.size() >= 3) begin
      check_eq("wrap_addr0", pcs[0], 64'hFFFF_FFFF_FFFF_FFF8);
      check_eq("wrap_addr1", pcs[1], 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("wrap_addr2", pcs[2], 64'h0);
    end

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           {$urandom, $urandom}, int'($urandom_range(1, 4)), $urandom_range(0, 4) != 0);
    end

    // Asynchronous reset with two entries filled and two responses still in flight.
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, '0, 2, 1);
    #1;
    check_eq("ar_pre_vld", 64'(ifid_valid), 64'd1);
    do_reset(1'b1);
    check_eq("ar_stale_pending", 64'(mem_q.size()), 64'd2);
    for (int k = 0; k < 4; k++) step(1, 0, 0, '0, 1, 1);
    first = -1;
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 0, '0, 1, 1);
      if (o_ivld && first < 0) begin
        first = 0;
        check_eq("ar_restart_pc", o_ipc, RST_PC);
      end
    end
    check_eq("ar_restarted", 64'(first), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
